// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the core's
// instruction-fetch read channel and its data read/write channel.
// One transaction is in flight at a time. Data requests win over fetch,
// except that a fetch kept waiting through STARVE_MAX data grants is forced.
//
// Handshake rule for every core-side channel: a transfer happens in a cycle
// where valid and ready are both high. Requests are granted combinationally
// in IDLE (ready is asserted in the same cycle as valid). Response valids
// (rvalid/bvalid) and their payloads are held stable until the matching
// ready is seen. A store requires awvalid and wvalid together; they are
// accepted in the same cycle or not at all.
module mem_port_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_MAX   = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch read channel
  input  logic [31:0] inst_araddr,
  input  logic        inst_arvalid,
  output logic        inst_arready,
  output logic [31:0] inst_rdata,
  output logic [1:0]  inst_rresp,
  output logic        inst_rvalid,
  input  logic        inst_rready,
  // data read channel
  input  logic [31:0] data_araddr,
  input  logic        data_arvalid,
  output logic        data_arready,
  output logic [31:0] data_rdata,
  output logic [1:0]  data_rresp,
  output logic        data_rvalid,
  input  logic        data_rready,
  // data write channel
  input  logic [31:0] data_awaddr,
  input  logic        data_awvalid,
  output logic        data_awready,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  input  logic        data_wvalid,
  output logic        data_wready,
  output logic [1:0]  data_bresp,
  output logic        data_bvalid,
  input  logic        data_bready,
  // flat memory port
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [1:0]  mem_mask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // debug visibility of the FSM and starvation counter
  output logic [1:0]  dbg_state,
  output logic [2:0]  dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_RESP = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LAST   = 3'(READ_LATENCY);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [1:0] MASK_NONE  = 2'b11;

  state_t      state, state_nxt;
  logic        gnt_inst, gnt_inst_nxt;
  logic [2:0]  lat_cnt, lat_cnt_nxt;
  logic [2:0]  starve_cnt, starve_cnt_nxt;
  logic [31:0] rbuf, rbuf_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [1:0]  bresp_q, bresp_nxt;

  logic        in_idle;
  logic        store_req;
  logic        fetch_forced;
  logic        grant_fetch;
  logic        grant_load;
  logic        grant_store;
  logic [1:0]  store_mask;
  logic        store_legal;

  // Only the three contiguous low-aligned strobe patterns map to a size.
  function automatic logic [1:0] strb_to_mask(input logic [3:0] strb);
    case (strb)
      4'b0001: strb_to_mask = 2'b00;
      4'b0011: strb_to_mask = 2'b01;
      4'b1111: strb_to_mask = 2'b10;
      default: strb_to_mask = MASK_NONE;
    endcase
  endfunction

  // Grant arbitration; grants are suppressed while rst is high so the
  // port stays quiet during reset.
  always_comb begin
    in_idle      = (state == IDLE) && !rst;
    store_req    = data_awvalid && data_wvalid;
    fetch_forced = inst_arvalid && (starve_cnt == STARVE_LIM);
    grant_fetch  = in_idle && inst_arvalid &&
                   (fetch_forced || (!store_req && !data_arvalid));
    grant_store  = in_idle && store_req && !fetch_forced;
    grant_load   = in_idle && data_arvalid && !store_req && !fetch_forced;
    store_mask   = strb_to_mask(data_wstrb);
    store_legal  = (store_mask != MASK_NONE);
  end

  // Next-state, register updates and all channel/memory outputs.
  always_comb begin
    state_nxt      = state;
    gnt_inst_nxt   = gnt_inst;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    rbuf_nxt       = rbuf;
    bresp_nxt      = bresp_q;

    inst_arready   = grant_fetch;
    data_arready   = grant_load;
    data_awready   = grant_store;
    data_wready    = grant_store;
    inst_rvalid    = 1'b0;
    data_rvalid    = 1'b0;
    data_bvalid    = 1'b0;

    mem_ren        = grant_fetch || grant_load;
    mem_wen        = grant_store && store_legal;
    mem_mask       = grant_store ? store_mask : MASK_NONE;
    mem_addr       = addr_q;
    mem_wdata      = wdata_q;
    if (grant_fetch) mem_addr = inst_araddr;
    if (grant_load)  mem_addr = data_araddr;
    if (grant_store) begin
      mem_addr  = data_awaddr;
      mem_wdata = data_wdata;
    end
    // address and write data hold their last driven value between grants
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;

    case (state)
      IDLE: begin
        if (grant_fetch || grant_load) begin
          gnt_inst_nxt = grant_fetch;
          lat_cnt_nxt  = 3'd1;
          state_nxt    = RD_WAIT;
        end else if (grant_store) begin
          bresp_nxt = store_legal ? 2'b00 : 2'b10;
          state_nxt = WR_RESP;
        end
        if (grant_fetch || !inst_arvalid) begin
          starve_cnt_nxt = 3'd0;
        end else if ((grant_load || grant_store) && (starve_cnt != STARVE_LIM)) begin
          starve_cnt_nxt = starve_cnt + 3'd1;
        end
      end
      RD_WAIT: begin
        lat_cnt_nxt = lat_cnt + 3'd1;
        if (lat_cnt == LAT_LAST) begin
          rbuf_nxt  = mem_rdata;
          state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        inst_rvalid = gnt_inst;
        data_rvalid = !gnt_inst;
        if (gnt_inst ? inst_rready : data_rready) state_nxt = IDLE;
      end
      WR_RESP: begin
        data_bvalid = 1'b1;
        if (data_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is presented from the capture buffer on both channels;
  // only the granted channel's rvalid qualifies it.
  assign inst_rdata     = rbuf;
  assign data_rdata     = rbuf;
  assign inst_rresp     = 2'b00;
  assign data_rresp     = 2'b00;
  assign data_bresp     = bresp_q;
  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  // State register with synchronous reset; an in-flight transaction is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_inst   <= 1'b0;
      lat_cnt    <= 3'd0;
      starve_cnt <= 3'd0;
      rbuf       <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      bresp_q    <= 2'b00;
    end else begin
      state      <= state_nxt;
      gnt_inst   <= gnt_inst_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      rbuf       <= rbuf_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      bresp_q    <= bresp_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a READ_LATENCY=1 instance carries most of
// the tests, a READ_LATENCY=3 instance covers reset during a read wait.
// Read responses of the main instance are checked through an expected queue.
module tb_mem_port_arbiter;

  localparam int RL   = 1;
  localparam int RL3  = 3;
  localparam int SMAX = 4;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst3;
  logic [31:0] inst_araddr, data_araddr, data_awaddr, data_wdata;
  logic        inst_arvalid, inst_rready, data_arvalid, data_rready;
  logic        data_awvalid, data_wvalid, data_bready;
  logic [3:0]  data_wstrb;

  // main instance outputs
  logic        inst_arready, inst_rvalid, data_arready, data_rvalid;
  logic        data_awready, data_wready, data_bvalid, mem_ren, mem_wen;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  inst_rresp, data_rresp, data_bresp, mem_mask, dbg_state;
  logic [2:0]  dbg_starve_cnt;

  // latency-3 instance outputs
  logic        inst_arready_3, inst_rvalid_3, data_arready_3, data_rvalid_3;
  logic        data_awready_3, data_wready_3, data_bvalid_3, mem_ren_3, mem_wen_3;
  logic [31:0] inst_rdata_3, data_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
  logic [1:0]  inst_rresp_3, data_rresp_3, data_bresp_3, mem_mask_3, dbg_state_3;
  logic [2:0]  dbg_starve_cnt_3;

  mem_port_arbiter #(.READ_LATENCY(RL), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .inst_araddr(inst_araddr), .inst_arvalid(inst_arvalid), .inst_arready(inst_arready),
    .inst_rdata(inst_rdata), .inst_rresp(inst_rresp), .inst_rvalid(inst_rvalid),
    .inst_rready(inst_rready),
    .data_araddr(data_araddr), .data_arvalid(data_arvalid), .data_arready(data_arready),
    .data_rdata(data_rdata), .data_rresp(data_rresp), .data_rvalid(data_rvalid),
    .data_rready(data_rready),
    .data_awaddr(data_awaddr), .data_awvalid(data_awvalid), .data_awready(data_awready),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_wvalid(data_wvalid),
    .data_wready(data_wready), .data_bresp(data_bresp), .data_bvalid(data_bvalid),
    .data_bready(data_bready),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_mask(mem_mask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  mem_port_arbiter #(.READ_LATENCY(RL3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .rst(rst3),
    .inst_araddr(inst_araddr), .inst_arvalid(inst_arvalid), .inst_arready(inst_arready_3),
    .inst_rdata(inst_rdata_3), .inst_rresp(inst_rresp_3), .inst_rvalid(inst_rvalid_3),
    .inst_rready(inst_rready),
    .data_araddr(data_araddr), .data_arvalid(data_arvalid), .data_arready(data_arready_3),
    .data_rdata(data_rdata_3), .data_rresp(data_rresp_3), .data_rvalid(data_rvalid_3),
    .data_rready(data_rready),
    .data_awaddr(data_awaddr), .data_awvalid(data_awvalid), .data_awready(data_awready_3),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_wvalid(data_wvalid),
    .data_wready(data_wready_3), .data_bresp(data_bresp_3), .data_bvalid(data_bvalid_3),
    .data_bready(data_bready),
    .mem_addr(mem_addr_3), .mem_ren(mem_ren_3), .mem_wen(mem_wen_3), .mem_mask(mem_mask_3),
    .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3),
    .dbg_state(dbg_state_3), .dbg_starve_cnt(dbg_starve_cnt_3)
  );

  // memory content model
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'h0000_0013 : ((a ^ 32'h5A5A_A5A5) + 32'd7);
  endfunction

  // memory models: data is valid only in the cycle exactly READ_LATENCY after ren
  logic [7:0]  pend1 = '0, pend3 = '0;
  logic [31:0] raddr1 = '0, raddr3 = '0;
  always @(posedge clk) begin
    pend1 <= {pend1[6:0], mem_ren};
    pend3 <= {pend3[6:0], mem_ren_3};
    if (mem_ren)   raddr1 <= mem_addr;
    if (mem_ren_3) raddr3 <= mem_addr_3;
  end
  assign mem_rdata   = pend1[RL-1]  ? rd_fn(raddr1) : 32'hDEAD_BEEF;
  assign mem_rdata_3 = pend3[RL3-1] ? rd_fn(raddr3) : 32'hDEAD_BEEF;

  int n_chk  = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];  // {is_fetch, rdata}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  // scoreboard: pop on every read handshake of the main instance
  always @(negedge clk) begin : rd_mon
    logic [32:0] e;
    if (!rst) begin
      if (inst_rvalid || data_rvalid)
        chk("rvalid_exclusive", 32'(inst_rvalid & data_rvalid), 32'd0);
      if ((inst_rvalid && inst_rready) || (data_rvalid && data_rready)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexpected: got rvalid inst=%0b data=%0b, expected none",
                   inst_rvalid, data_rvalid);
        end else begin
          e = exp_q.pop_front();
          chk("rd_channel", 32'(inst_rvalid), 32'(e[32]));
          chk("rd_data", inst_rvalid ? inst_rdata : data_rdata, e[31:0]);
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_mask;
    logic        exp_wen;
    logic [1:0]  exp_bresp;
  } vec_t;

  vec_t vecs[10];

  task automatic idle_inputs();
    inst_arvalid = 1'b0; data_arvalid = 1'b0;
    data_awvalid = 1'b0; data_wvalid  = 1'b0;
  endtask

  function automatic logic granted(input logic [1:0] kind);
    case (kind)
      K_FETCH: return inst_arready;
      K_LOAD:  return data_arready;
      default: return data_awready & data_wready;
    endcase
  endfunction

  // one complete transaction on the main instance, with cycle-exact checks
  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    int cnt;
    cyc();
    inst_rready = 1'b1; data_rready = 1'b1; data_bready = 1'b1;
    case (v.kind)
      K_FETCH: begin
        inst_araddr = v.addr; inst_arvalid = 1'b1;
        exp_q.push_back({1'b1, rd_fn(v.addr)});
      end
      K_LOAD: begin
        data_araddr = v.addr; data_arvalid = 1'b1;
        exp_q.push_back({1'b0, rd_fn(v.addr)});
      end
      default: begin
        data_awaddr = v.addr; data_wdata = v.wdata; data_wstrb = v.wstrb;
        data_awvalid = 1'b1; data_wvalid = 1'b1;
      end
    endcase
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      smp();
      if (granted(v.kind)) begin got = 1'b1; break; end
      cyc();
    end
    chk($sformatf("v%0d_grant", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
    chk($sformatf("v%0d_mem_mask", idx), 32'(mem_mask), 32'(v.exp_mask));
    if (v.kind == K_STORE) begin
      chk($sformatf("v%0d_mem_wen", idx), 32'(mem_wen), 32'(v.exp_wen));
      chk($sformatf("v%0d_mem_ren", idx), 32'(mem_ren), 32'd0);
      chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
    end else begin
      chk($sformatf("v%0d_mem_ren", idx), 32'(mem_ren), 32'd1);
      chk($sformatf("v%0d_mem_wen", idx), 32'(mem_wen), 32'd0);
    end
    cyc();
    idle_inputs();
    if (v.kind == K_STORE) begin
      smp();
      chk($sformatf("v%0d_bvalid", idx), 32'(data_bvalid), 32'd1);
      chk($sformatf("v%0d_bresp", idx), 32'(data_bresp), 32'(v.exp_bresp));
    end else begin
      got = 1'b0;
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
        smp();
        cnt++;
        if (inst_rvalid || data_rvalid) begin got = 1'b1; break; end
        cyc();
      end
      chk($sformatf("v%0d_rvalid_seen", idx), 32'(got), 32'd1);
      chk($sformatf("v%0d_rd_latency", idx), 32'(cnt), 32'(RL + 1));
    end
    cyc();
    smp();
    chk($sformatf("v%0d_back_idle", idx), 32'(dbg_state), 32'd0);
    chk($sformatf("v%0d_bvalid_low", idx), 32'(data_bvalid), 32'd0);
  endtask

  // wait (bounded) for rvalid on one channel of the main instance
  task automatic wait_rvalid(input bit inst, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      smp();
      if (inst ? inst_rvalid : data_rvalid) begin got = 1'b1; break; end
      cyc();
    end
    chk(name, 32'(got), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit   got;
    int   cnt, loads, seen;
    vec_t rv;

    vecs[0] = '{K_FETCH, 32'h0000_1000, 32'h0,         4'b0000, 2'b11, 1'b0, 2'b00};
    vecs[1] = '{K_LOAD,  32'h2000_0040, 32'h0,         4'b0000, 2'b11, 1'b0, 2'b00};
    vecs[2] = '{K_FETCH, 32'h0000_0104, 32'h0,         4'b0000, 2'b11, 1'b0, 2'b00};
    vecs[3] = '{K_STORE, 32'h8000_0004, 32'h0000_00A5, 4'b0001, 2'b00, 1'b1, 2'b00};
    vecs[4] = '{K_STORE, 32'h8000_0010, 32'h1234_5678, 4'b0011, 2'b01, 1'b1, 2'b00};
    vecs[5] = '{K_STORE, 32'h8000_0020, 32'hCAFE_F00D, 4'b1111, 2'b10, 1'b1, 2'b00};
    vecs[6] = '{K_STORE, 32'h8000_0030, 32'h0000_0BAD, 4'b0110, 2'b11, 1'b0, 2'b10};
    vecs[7] = '{K_STORE, 32'h8000_0034, 32'h1111_2222, 4'b0000, 2'b11, 1'b0, 2'b10};
    vecs[8] = '{K_STORE, 32'h8000_0038, 32'h3333_4444, 4'b1000, 2'b11, 1'b0, 2'b10};
    vecs[9] = '{K_LOAD,  32'hFFFF_FFFC, 32'h0,         4'b0000, 2'b11, 1'b0, 2'b00};

    rst = 1'b1; rst3 = 1'b1;
    inst_araddr = '0; data_araddr = '0; data_awaddr = '0; data_wdata = '0; data_wstrb = '0;
    inst_rready = 1'b0; data_rready = 1'b0; data_bready = 1'b0;
    idle_inputs();
    repeat (3) cyc();
    rst = 1'b0;
    smp();
    // reset state
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_inst_arready", 32'(inst_arready), 32'd0);
    chk("rst_data_arready", 32'(data_arready), 32'd0);
    chk("rst_awready", 32'(data_awready), 32'd0);
    chk("rst_wready", 32'(data_wready), 32'd0);
    chk("rst_inst_rvalid", 32'(inst_rvalid), 32'd0);
    chk("rst_data_rvalid", 32'(data_rvalid), 32'd0);
    chk("rst_bvalid", 32'(data_bvalid), 32'd0);
    chk("rst_bresp", 32'(data_bresp), 32'd0);
    chk("rst_mem_ren", 32'(mem_ren), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_mask", 32'(mem_mask), 32'd3);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_starve", 32'(dbg_starve_cnt), 32'd0);
    chk("rst_rresp", 32'({inst_rresp, data_rresp}), 32'd0);

    // table-driven single transactions
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // store and fetch together: store first, fetch right after bready cycle
    cyc();
    data_awaddr = 32'h8000_0004; data_wdata = 32'h0000_00A5; data_wstrb = 4'b0001;
    data_awvalid = 1'b1; data_wvalid = 1'b1;
    inst_araddr = 32'h0000_2000; inst_arvalid = 1'b1;
    exp_q.push_back({1'b1, rd_fn(32'h0000_2000)});
    smp();
    chk("sf_awready", 32'(data_awready & data_wready), 32'd1);
    chk("sf_no_fetch", 32'(inst_arready), 32'd0);
    chk("sf_mem_wen", 32'(mem_wen), 32'd1);
    chk("sf_mem_mask", 32'(mem_mask), 32'd0);
    chk("sf_mem_addr", mem_addr, 32'h8000_0004);
    cyc();
    data_awvalid = 1'b0; data_wvalid = 1'b0;
    smp();
    chk("sf_bvalid", 32'(data_bvalid), 32'd1);
    chk("sf_bresp", 32'(data_bresp), 32'd0);
    chk("sf_fetch_waits", 32'(inst_arready), 32'd0);
    cyc();
    smp();
    chk("sf_fetch_grant", 32'(inst_arready), 32'd1);
    chk("sf_fetch_addr", mem_addr, 32'h0000_2000);
    cyc();
    inst_arvalid = 1'b0;
    wait_rvalid(1'b1, "sf_fetch_rvalid");
    cyc();
    smp();
    chk("sf_idle", 32'(dbg_state), 32'd0);

    // backpressure: load response held while rready low for 5 cycles
    cyc();
    data_araddr = 32'h3000_0008; data_arvalid = 1'b1; data_rready = 1'b0;
    exp_q.push_back({1'b0, rd_fn(32'h3000_0008)});
    smp();
    chk("bp_arready", 32'(data_arready), 32'd1);
    cyc();
    data_arvalid = 1'b0;
    wait_rvalid(1'b0, "bp_rvalid");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin cyc(); smp(); end
      chk($sformatf("bp_rvalid_%0d", k), 32'(data_rvalid), 32'd1);
      chk($sformatf("bp_rdata_%0d", k), data_rdata, rd_fn(32'h3000_0008));
      chk($sformatf("bp_no_ren_%0d", k), 32'(mem_ren), 32'd0);
    end
    cyc();
    data_rready = 1'b1;
    smp();
    chk("bp_release_valid", 32'(data_rvalid), 32'd1);
    cyc();
    smp();
    chk("bp_idle", 32'(dbg_state), 32'd0);
    chk("bp_rvalid_low", 32'(data_rvalid), 32'd0);

    // starvation: continuous loads with a pending fetch
    cyc();
    data_araddr = 32'h4000_0000; data_arvalid = 1'b1;
    inst_araddr = 32'h0000_0200; inst_arvalid = 1'b1;
    inst_rready = 1'b1; data_rready = 1'b1;
    for (int k = 0; k < SMAX; k++) exp_q.push_back({1'b0, rd_fn(32'h4000_0000)});
    exp_q.push_back({1'b1, rd_fn(32'h0000_0200)});
    loads = 0;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      smp();
      if (inst_arready) begin got = 1'b1; break; end
      if (data_arready) loads++;
      cyc();
    end
    chk("sv_fetch_forced", 32'(got), 32'd1);
    chk("sv_load_grants", 32'(loads), 32'(SMAX));
    chk("sv_starve_at_force", 32'(dbg_starve_cnt), 32'(SMAX));
    cyc();
    idle_inputs();
    smp();
    chk("sv_starve_clear", 32'(dbg_starve_cnt), 32'd0);
    wait_rvalid(1'b1, "sv_fetch_rvalid");
    cyc();
    smp();
    chk("sv_idle", 32'(dbg_state), 32'd0);

    // randomised reads
    for (int i = 0; i < 6; i++) begin
      rv = '{K_FETCH, 32'h0, 32'h0, 4'b0000, 2'b11, 1'b0, 2'b00};
      rv.kind = 2'($urandom_range(0, 1));
      rv.addr = $urandom() & 32'hFFFF_FFFC;
      run_vec(rv, 100 + i);
    end

    // latency-3 instance: reset during RD_WAIT, then a fresh fetch
    cyc();
    rst = 1'b1; rst3 = 1'b0;
    cyc();
    inst_araddr = 32'h0000_4000; inst_arvalid = 1'b1; inst_rready = 1'b1;
    smp();
    chk("l3_grant", 32'(inst_arready_3 & mem_ren_3), 32'd1);
    cyc();
    inst_arvalid = 1'b0;
    smp();
    chk("l3_rd_wait", 32'(dbg_state_3), 32'd1);
    cyc();
    rst3 = 1'b1;
    cyc();
    rst3 = 1'b0;
    smp();
    chk("l3_rst_state", 32'(dbg_state_3), 32'd0);
    chk("l3_rst_rvalid", 32'({inst_rvalid_3, data_rvalid_3, data_bvalid_3}), 32'd0);
    chk("l3_rst_ready", 32'({inst_arready_3, data_arready_3, data_awready_3, data_wready_3}), 32'd0);
    chk("l3_rst_strobes", 32'({mem_ren_3, mem_wen_3}), 32'd0);
    chk("l3_rst_mask", 32'(mem_mask_3), 32'd3);
    chk("l3_rst_addr", mem_addr_3, 32'd0);
    chk("l3_rst_wdata", mem_wdata_3, 32'd0);
    chk("l3_rst_bresp", 32'(data_bresp_3), 32'd0);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      cyc(); smp();
      if (inst_rvalid_3 || data_rvalid_3) seen++;
    end
    chk("l3_no_rvalid_after_abort", 32'(seen), 32'd0);
    cyc();
    inst_araddr = 32'h0000_4100; inst_arvalid = 1'b1;
    smp();
    chk("l3_fresh_grant", 32'(inst_arready_3), 32'd1);
    cyc();
    inst_arvalid = 1'b0;
    got = 1'b0;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      smp();
      cnt++;
      if (inst_rvalid_3) begin got = 1'b1; break; end
      cyc();
    end
    chk("l3_rvalid_seen", 32'(got), 32'd1);
    chk("l3_rd_latency", 32'(cnt), 32'(RL3 + 1));
    chk("l3_rdata", inst_rdata_3, rd_fn(32'h0000_4100));
    cyc();
    smp();
    chk("l3_idle", 32'(dbg_state_3), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
